// File: rtl/ram_fifo_pkg.sv
// Shared constants, entry layout and the round-robin search used by ram_fifo_arbiter.
// Default geometry: 16-bit payload, 256 entries, up to 4 requesters.
package ram_fifo_pkg;

  localparam int DATA_SIZE_DEF = 16;
  localparam int ADDR_SIZE_DEF = 8;
  localparam int ID_W_DEF      = 2;
  localparam int MAX_REQ       = 4;
  localparam int DEPTH         = 2 ** ADDR_SIZE_DEF;

  typedef logic [ADDR_SIZE_DEF:0] ptr_t;

  typedef struct packed {
    logic [ID_W_DEF-1:0]      src;
    logic [DATA_SIZE_DEF-1:0] data;
  } entry_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } grant_t;

  // First asserted valid at or after prio, wrapping modulo n (n <= MAX_REQ).
  function automatic grant_t rr_next(input logic [1:0] prio,
                                     input logic [MAX_REQ-1:0] valid,
                                     input int n);
    grant_t     r;
    logic [1:0] c;
    r = '{found: 1'b0, idx: 2'd0};
    for (int k = 0; k < MAX_REQ; k++) begin
      c = 2'((int'(prio) + k) % n);
      if (k < n && !r.found && valid[c]) begin
        r.found = 1'b1;
        r.idx   = c;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_fifo_arbiter_dual_ram.sv
// Simple dual-port RAM: synchronous write port, combinational read port.
// No reset on contents; a write becomes readable from the following cycle.
module ram_fifo_arbiter_dual_ram #(
  parameter int DATA_SIZE = 18,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 wclken,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];

  always_ff @(posedge clk) begin
    if (wclken) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_fifo_arbiter.sv
// Round-robin arbiter sharing one RAM write port between N_REQ producers, with a
// FWFT ring-buffer read side that returns each word tagged with its source ID.
module ram_fifo_arbiter
  import ram_fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int N_REQ     = 2,
  parameter int ID_W      = ID_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_SIZE-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [DATA_SIZE-1:0]       rd_data,
  output logic [ID_W-1:0]            rd_src,
  output logic [ADDR_SIZE:0]         count,
  output logic                       full,
  output logic                       underflow_err
);

  typedef logic [ADDR_SIZE:0] lptr_t;

  typedef struct packed {
    logic [ID_W-1:0]      src;
    logic [DATA_SIZE-1:0] data;
  } lentry_t;

  lptr_t      wptr, rptr;
  logic [1:0] prio, next_prio;
  grant_t     grant;
  logic       push, pop, empty;
  lentry_t    wentry, rentry;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[ADDR_SIZE] != rptr[ADDR_SIZE]) &&
                    (wptr[ADDR_SIZE-1:0] == rptr[ADDR_SIZE-1:0]);
  assign count    = wptr - rptr;
  assign rd_valid = !empty;
  assign pop      = rd_en && !empty;

  // Grant is blocked while full so the ready path never depends on a same-cycle pop.
  always_comb begin
    grant       = rr_next(prio, MAX_REQ'(req_valid), N_REQ);
    push        = grant.found && !full && !rst;
    req_ready   = push ? N_REQ'(MAX_REQ'(1) << grant.idx) : '0;
    next_prio   = 2'((int'(grant.idx) + 1) % N_REQ);
    wentry.src  = ID_W'(grant.idx);
    wentry.data = req_data[int'(grant.idx)*DATA_SIZE +: DATA_SIZE];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      prio          <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + lptr_t'(1);
        prio <= next_prio;
      end
      if (pop) rptr <= rptr + lptr_t'(1);
      if (rd_en && empty) underflow_err <= 1'b1;
    end
  end

  logic [ID_W+DATA_SIZE-1:0] ram_rdata;

  ram_fifo_arbiter_dual_ram #(
    .DATA_SIZE(ID_W + DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk   (clk),
    .wclken(push),
    .waddr (wptr[ADDR_SIZE-1:0]),
    .wdata (wentry),
    .raddr (rptr[ADDR_SIZE-1:0]),
    .rdata (ram_rdata)
  );

  assign rentry  = ram_rdata;
  assign rd_data = rentry.data;
  assign rd_src  = rentry.src;

endmodule

// File: tb/tb_ram_fifo_arbiter.sv
// Bench for ram_fifo_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ram_fifo_arbiter;

  localparam int DS = 16;
  localparam int AS = 8;
  localparam int NR = 2;
  localparam int IW = 2;
  localparam int DEP = 2 ** AS;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DS-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rd_en;
  logic            rd_valid;
  logic [DS-1:0]   rd_data;
  logic [IW-1:0]   rd_src;
  logic [AS:0]     count;
  logic            full;
  logic            underflow_err;

  ram_fifo_arbiter #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .N_REQ(NR), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_src(rd_src), .count(count), .full(full), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of {src, data}, RR priority, sticky underflow flag.
  logic [IW+DS-1:0] mq[$];
  int               mprio = 0;
  logic             muf   = 1'b0;
  logic             chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      int g;
      logic [NR-1:0] exp_ready;
      g = -1;
      exp_ready = '0;
      if (!rst && mq.size() < DEP) begin
        for (int k = 0; k < NR; k++) begin
          if (g < 0 && req_valid[(mprio + k) % NR]) g = (mprio + k) % NR;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("count", 32'(count), mq.size());
      check("full", 32'(full), 32'(mq.size() == DEP));
      check("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
      check("underflow_err", 32'(underflow_err), 32'(muf));
      if (mq.size() != 0) begin
        check("rd_data", 32'(rd_data), 32'(mq[0][DS-1:0]));
        check("rd_src", 32'(rd_src), 32'(mq[0][IW+DS-1:DS]));
      end
      if (rst) begin
        mq.delete();
        mprio = 0;
        muf   = 1'b0;
      end else begin
        if (rd_en && mq.size() != 0) void'(mq.pop_front());
        else if (rd_en) muf = 1'b1;
        if (g >= 0) begin
          mq.push_back({IW'(g), req_data[g*DS +: DS]});
          mprio = (g + 1) % NR;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    while (rd_valid && n < 400) begin
      rd_en = 1'b1;
      step();
      n++;
    end
    rd_en = 1'b0;
    check("drain_empty", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; rd_en = 1'b0;
    @(posedge clk);
    chk_on = 1'b1;
    #1;
    settle();
    check("reset_count", 32'(count), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;

    // Alternating grants with both requesters valid.
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      req_data = {16'hB000 + 16'(i), 16'hA000 + 16'(i)};
      settle();
      check("alt_grant", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      step();
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      settle();
      check("alt_src", 32'(rd_src), i % 2);
      check("alt_data", 32'(rd_data), (i % 2 == 0) ? 32'hA000 + i : 32'hB000 + i);
      step();
    end
    rd_en = 1'b0;

    // Fill completely from requester 1.
    req_valid = 2'b10;
    for (int i = 0; i < DEP; i++) begin
      req_data = {16'(16'h4000 + i), 16'hDEAD};
      step();
    end
    settle();
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd256);
    check("fill_ready0", 32'(req_ready), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    settle();
    check("pop_unfull", 32'(full), 32'd0);
    check("pop_ready", 32'(req_ready), 32'd2);
    step();
    drain();

    // Steady push and pop at count 5.
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      req_data = {16'h0, 16'(16'h5000 + i)};
      step();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_data = {16'h0, 16'(16'h5100 + i)};
      settle();
      check("steady_count", 32'(count), 32'd5);
      step();
    end
    drain();

    // Long continuous stream across the pointer wrap.
    req_valid = 2'b11;
    req_data  = {16'h6000, 16'h7000};
    step();
    rd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      req_data = {16'(16'h6000 + i), 16'(16'h7000 + i)};
      step();
    end
    settle();
    check("wrap_count", 32'(count), 32'd1);
    drain();

    // Underflow and its clearing by reset.
    rd_en = 1'b1;
    step();
    step();
    rd_en = 1'b0;
    settle();
    check("uflow_set", 32'(underflow_err), 32'd1);
    check("uflow_count", 32'(count), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("uflow_clear", 32'(underflow_err), 32'd0);

    // Reset in the middle of a stream.
    req_valid = 2'b01;
    for (int i = 0; i < 17; i++) begin
      req_data = {16'h0, 16'(16'h8000 + i)};
      step();
    end
    settle();
    check("pre_rst_count", 32'(count), 32'd17);
    req_valid = 2'b11;
    rst = 1'b1;
    settle();
    check("rst_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    settle();
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_valid", 32'(rd_valid), 32'd0);
    check("post_rst_full", 32'(full), 32'd0);
    check("post_rst_grant", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    drain();

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
